oc0a_perst_seq: RTL and testbench

Reset and link-bring-up sequencer for the downstream x4 NVMe port (oc0a). It sits beside the block design and owns the slot's PERST# (`oc0a_perstn`) and the reset of the oc0a root-port core. It gates both on host PERST# and reference-clock lock, and holds PERST# for a programmed minimum. It then waits for link-up within a timeout and retries a bounded number of times, reporting status to the host-side register file.

---
 rtl/oc0a_perst_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_oc0a_perst_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oc0a_perst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : oc0a_perst_seq
//  Purpose  : Reset and link bring-up sequencer for the downstream x4 NVMe
//             port (oc0a). Owns the slot PERST# and the root-port core reset,
//             gates both on host PERST# and refclk lock, holds PERST# for a
//             programmed minimum, then waits for link-up within a timeout and
//             retries a bounded number of times before declaring failure.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1  free-running system clock (not oc0a refclk)
//    rstn           in   1  asynchronous active-low reset
//    host_perstn    in   1  host slot PERST#, async, synchronized inside
//    refclk_locked  in   1  oc0a refclk/GT lock, async, synchronized inside
//    link_up        in   1  root-port link-up, synchronous to clk
//    sw_reset_req   in   1  single-cycle re-sequence request
//    oc0a_perstn    out  1  downstream PERST# (registered)
//    rp_rstn        out  1  active-low root-port core reset (registered)
//    link_ready     out  1  high only in UP
//    fail           out  1  high only in FAIL
//    state          out  3  current state encoding
//    retry_cnt      out  4  consecutive link-up timeouts
//    down_cnt       out  8  link-loss events seen in UP, saturating
// ============================================================================
module oc0a_perst_seq #(
    parameter int T_PERST   = 25_000_000,
    parameter int T_LINK    = 25_000_000,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       host_perstn,
    input  logic       refclk_locked,
    input  logic       link_up,
    input  logic       sw_reset_req,
    output logic       oc0a_perstn,
    output logic       rp_rstn,
    output logic       link_ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] down_cnt
);

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_WAIT_CLK = 3'd1,
        S_HOLD     = 3'd2,
        S_TRAIN    = 3'd3,
        S_UP       = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_PERST_LAST = CNT_W'(T_PERST - 1);
    localparam logic [CNT_W-1:0] C_LINK_LAST  = CNT_W'(T_LINK - 1);
    localparam logic [3:0]       C_MAX_RETRY  = 4'(MAX_RETRY);
    localparam logic [7:0]       C_DOWN_SAT   = 8'hFF;

    // ------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous qualifiers
    // ------------------------------------------------------------------------
    logic [1:0] r_host_sync;
    logic [1:0] r_lock_sync;
    logic       w_host_ok;
    logic       w_lock_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_host_sync <= 2'b00;
            r_lock_sync <= 2'b00;
        end else begin
            r_host_sync <= {r_host_sync[0], host_perstn};
            r_lock_sync <= {r_lock_sync[0], refclk_locked};
        end
    end

    assign w_host_ok = r_host_sync[1];
    assign w_lock_ok = r_lock_sync[1];

    // ------------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry_cnt;
    logic [7:0]       r_down_cnt;
    logic             r_perstn;
    logic             r_rp_rstn;
    logic             r_link_ready;
    logic             r_fail;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_retry_nxt;
    logic [3:0]       w_retry_inc;
    logic [7:0]       w_down_nxt;
    logic             w_perstn_nxt;
    logic             w_rp_rstn_nxt;
    logic             w_link_ready_nxt;
    logic             w_fail_nxt;

    assign w_retry_inc = r_retry_cnt + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state, counter and status decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        w_down_nxt  = r_down_cnt;
        // The counter only runs while timing HOLD or TRAIN; every transition
        // below clears it explicitly so each window starts at zero.
        if ((r_state == S_HOLD) || (r_state == S_TRAIN)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = '0;
        end

        case (r_state)
            S_RESET: begin
                w_state_nxt = S_WAIT_CLK;
            end
            S_WAIT_CLK: begin
                if (w_host_ok && w_lock_ok) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            S_HOLD: begin
                if (r_cnt == C_PERST_LAST) begin
                    w_state_nxt = S_TRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_TRAIN: begin
                // Link-up is checked first so it wins over a timeout landing
                // on the same cycle.
                if (link_up) begin
                    w_state_nxt = S_UP;
                    w_retry_nxt = 4'd0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_LINK_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_cnt_nxt   = '0;
                    if (w_retry_inc == C_MAX_RETRY) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_UP: begin
                if (!link_up) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    if (r_down_cnt != C_DOWN_SAT) begin
                        w_down_nxt = r_down_cnt + 8'd1;
                    end
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_RESET;
                w_cnt_nxt   = '0;
            end
        endcase

        // Global overrides replace whatever the per-state step decided,
        // including any link-loss count it would have taken.
        if (!w_host_ok || !w_lock_ok) begin
            w_state_nxt = S_WAIT_CLK;
            w_cnt_nxt   = '0;
            w_retry_nxt = 4'd0;
            w_down_nxt  = r_down_cnt;
        end else if (sw_reset_req && (r_state != S_RESET) && (r_state != S_WAIT_CLK)) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_retry_nxt = 4'd0;
            w_down_nxt  = r_down_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs change on
    // the same edge as the state register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_perstn_nxt     = 1'b0;
        w_rp_rstn_nxt    = 1'b0;
        w_link_ready_nxt = 1'b0;
        w_fail_nxt       = 1'b0;
        case (w_state_nxt)
            S_HOLD: begin
                w_rp_rstn_nxt = 1'b1;
            end
            S_TRAIN: begin
                w_perstn_nxt  = 1'b1;
                w_rp_rstn_nxt = 1'b1;
            end
            S_UP: begin
                w_perstn_nxt     = 1'b1;
                w_rp_rstn_nxt    = 1'b1;
                w_link_ready_nxt = 1'b1;
            end
            S_FAIL: begin
                w_rp_rstn_nxt = 1'b1;
                w_fail_nxt    = 1'b1;
            end
            default: begin
                w_perstn_nxt  = 1'b0;
                w_rp_rstn_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_retry_cnt  <= 4'd0;
            r_down_cnt   <= 8'd0;
            r_perstn     <= 1'b0;
            r_rp_rstn    <= 1'b0;
            r_link_ready <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry_cnt  <= w_retry_nxt;
            r_down_cnt   <= w_down_nxt;
            r_perstn     <= w_perstn_nxt;
            r_rp_rstn    <= w_rp_rstn_nxt;
            r_link_ready <= w_link_ready_nxt;
            r_fail       <= w_fail_nxt;
        end
    end

    assign oc0a_perstn = r_perstn;
    assign rp_rstn     = r_rp_rstn;
    assign link_ready  = r_link_ready;
    assign fail        = r_fail;
    assign state       = r_state;
    assign retry_cnt   = r_retry_cnt;
    assign down_cnt    = r_down_cnt;

endmodule
`default_nettype wire

// File: tb/tb_oc0a_perst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oc0a_perst_seq
//  Purpose  : Self-checking bench for oc0a_perst_seq. Scenario tasks drive
//             randomized timing and compare against expectations derived from
//             the sequencing rules (window lengths, retry/down bookkeeping).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oc0a_perst_seq;

    localparam int T_PERST   = 16;
    localparam int T_LINK    = 32;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 8;

    localparam logic [2:0] S_RESET = 3'd0, S_WAIT = 3'd1, S_HOLD = 3'd2,
                           S_TRAIN = 3'd3, S_UP = 3'd4, S_FAIL = 3'd5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       host_perstn = 1'b0;
    logic       refclk_locked = 1'b0;
    logic       link_up = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       oc0a_perstn, rp_rstn, link_ready, fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] down_cnt;

    int compared   = 0;
    int mismatched = 0;
    int down_exp   = 0;
    int retry_exp  = 0;

    always #5 clk = ~clk;

    oc0a_perst_seq #(
        .T_PERST(T_PERST), .T_LINK(T_LINK), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .host_perstn(host_perstn),
        .refclk_locked(refclk_locked), .link_up(link_up),
        .sw_reset_req(sw_reset_req), .oc0a_perstn(oc0a_perstn),
        .rp_rstn(rp_rstn), .link_ready(link_ready), .fail(fail),
        .state(state), .retry_cnt(retry_cnt), .down_cnt(down_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until state equals s; n = ticks taken, or -1 on budget expiry.
    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        if (state !== s) n = -1;
    endtask

    // Ticks until state differs from s; n = ticks taken, or -1 on expiry.
    task automatic wait_leave(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state === s && n < budget) begin
            tick();
            n++;
        end
        if (state === s) n = -1;
    endtask

    task automatic test_reset();
        ticks(3);
        compared++; if (state !== S_RESET) begin mismatched++; $display("FAIL reset_state: got %0d want %0d", state, S_RESET); end
        compared++; if (oc0a_perstn !== 1'b0 || rp_rstn !== 1'b0) begin mismatched++; $display("FAIL reset_resets: got perstn=%b rp=%b want 0 0", oc0a_perstn, rp_rstn); end
        compared++; if (link_ready !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got ready=%b fail=%b want 0 0", link_ready, fail); end
        compared++; if (retry_cnt !== 4'd0 || down_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_counts: got retry=%0d down=%0d want 0 0", retry_cnt, down_cnt); end
        rstn = 1'b1;
        tick();
        compared++; if (state !== S_WAIT) begin mismatched++; $display("FAIL release_wait: got %0d want %0d", state, S_WAIT); end
    endtask

    task automatic test_nominal();
        int n;
        int k;
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_state(S_HOLD, 10, n);
        compared++; if (n !== 3) begin mismatched++; $display("FAIL sync_latency: got %0d want 3", n); end
        compared++; if (oc0a_perstn !== 1'b0 || rp_rstn !== 1'b1) begin mismatched++; $display("FAIL hold_outputs: got perstn=%b rp=%b want 0 1", oc0a_perstn, rp_rstn); end
        wait_state(S_TRAIN, 40, n);
        compared++; if (n !== T_PERST) begin mismatched++; $display("FAIL hold_length: got %0d want %0d", n, T_PERST); end
        compared++; if (oc0a_perstn !== 1'b1) begin mismatched++; $display("FAIL train_perstn: got %b want 1", oc0a_perstn); end
        k = $urandom_range(T_LINK - 2, 0);
        ticks(k);
        compared++; if (state !== S_TRAIN) begin mismatched++; $display("FAIL train_wait k=%0d: got %0d want %0d", k, state, S_TRAIN); end
        link_up = 1'b1;
        tick();
        compared++; if (state !== S_UP || link_ready !== 1'b1) begin mismatched++; $display("FAIL nominal_up: got state=%0d ready=%b want 4 1", state, link_ready); end
        compared++; if (retry_cnt !== 4'(retry_exp)) begin mismatched++; $display("FAIL nominal_retry: got %0d want %0d", retry_cnt, retry_exp); end
    endtask

    task automatic test_link_loss();
        int n;
        int loops;
        loops = $urandom_range(3, 1);
        for (int i = 0; i < loops; i++) begin
            link_up = 1'b0;
            tick();
            down_exp++;
            link_up = 1'b1;
            compared++; if (state !== S_HOLD || link_ready !== 1'b0) begin mismatched++; $display("FAIL loss_hold: got state=%0d ready=%b want 2 0", state, link_ready); end
            compared++; if (down_cnt !== 8'(down_exp)) begin mismatched++; $display("FAIL loss_down_cnt: got %0d want %0d", down_cnt, down_exp); end
            compared++; if (oc0a_perstn !== 1'b0) begin mismatched++; $display("FAIL loss_perstn: got %b want 0", oc0a_perstn); end
            wait_state(S_TRAIN, 40, n);
            compared++; if (n !== T_PERST) begin mismatched++; $display("FAIL loss_hold_length: got %0d want %0d", n, T_PERST); end
            tick();
            compared++; if (state !== S_UP) begin mismatched++; $display("FAIL loss_relink: got %0d want %0d", state, S_UP); end
        end
    endtask

    task automatic test_retry_fail();
        int n;
        logic [2:0] exp_s;
        link_up = 1'b0;
        tick();
        down_exp++;
        for (int r = 0; r < MAX_RETRY; r++) begin
            wait_state(S_TRAIN, 40, n);
            compared++; if (n !== T_PERST) begin mismatched++; $display("FAIL retry_hold_length: got %0d want %0d", n, T_PERST); end
            wait_leave(S_TRAIN, 80, n);
            compared++; if (n !== T_LINK) begin mismatched++; $display("FAIL retry_train_length: got %0d want %0d", n, T_LINK); end
            retry_exp++;
            exp_s = (retry_exp == MAX_RETRY) ? S_FAIL : S_HOLD;
            compared++; if (state !== exp_s || retry_cnt !== 4'(retry_exp)) begin mismatched++; $display("FAIL retry_step: got state=%0d retry=%0d want %0d %0d", state, retry_cnt, exp_s, retry_exp); end
            compared++; if (oc0a_perstn !== 1'b0) begin mismatched++; $display("FAIL retry_perstn: got %b want 0", oc0a_perstn); end
        end
        ticks($urandom_range(20, 1));
        compared++; if (state !== S_FAIL || fail !== 1'b1 || rp_rstn !== 1'b1) begin mismatched++; $display("FAIL fail_sticky: got state=%0d fail=%b rp=%b want 5 1 1", state, fail, rp_rstn); end
        compared++; if (down_cnt !== 8'(down_exp)) begin mismatched++; $display("FAIL fail_down_cnt: got %0d want %0d", down_cnt, down_exp); end
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        retry_exp = 0;
        compared++; if (state !== S_HOLD || retry_cnt !== 4'd0 || fail !== 1'b0) begin mismatched++; $display("FAIL sw_from_fail: got state=%0d retry=%0d fail=%b want 2 0 0", state, retry_cnt, fail); end
    endtask

    task automatic test_simultaneous();
        int n;
        int k;
        wait_state(S_TRAIN, 40, n);
        wait_leave(S_TRAIN, 80, n);
        retry_exp = 1;
        compared++; if (state !== S_HOLD || retry_cnt !== 4'(retry_exp)) begin mismatched++; $display("FAIL sim_first_timeout: got state=%0d retry=%0d want 2 1", state, retry_cnt); end
        wait_state(S_TRAIN, 40, n);
        ticks(T_LINK - 1);
        compared++; if (state !== S_TRAIN) begin mismatched++; $display("FAIL sim_before_last: got %0d want %0d", state, S_TRAIN); end
        link_up = 1'b1;
        tick();
        retry_exp = 0;
        compared++; if (state !== S_UP || retry_cnt !== 4'd0) begin mismatched++; $display("FAIL link_beats_timeout: got state=%0d retry=%0d want 4 0", state, retry_cnt); end
        link_up = 1'b0;
        tick();
        down_exp++;
        wait_state(S_TRAIN, 40, n);
        k = $urandom_range(T_LINK - 2, 0);
        ticks(k);
        link_up      = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        compared++; if (state !== S_HOLD || oc0a_perstn !== 1'b0) begin mismatched++; $display("FAIL sw_beats_link: got state=%0d perstn=%b want 2 0", state, oc0a_perstn); end
        wait_state(S_TRAIN, 40, n);
        compared++; if (n !== T_PERST) begin mismatched++; $display("FAIL sw_hold_length: got %0d want %0d", n, T_PERST); end
        tick();
        compared++; if (state !== S_UP) begin mismatched++; $display("FAIL sw_relink: got %0d want %0d", state, S_UP); end
    endtask

    task automatic test_host_perst();
        int n;
        int k;
        int drop;
        link_up = 1'b0;
        tick();
        down_exp++;
        wait_state(S_TRAIN, 40, n);
        wait_leave(S_TRAIN, 80, n);
        retry_exp = 1;
        wait_state(S_TRAIN, 40, n);
        k = $urandom_range(T_LINK - 5, 0);
        ticks(k);
        drop = $urandom_range(1, 0);
        if (drop == 1) host_perstn = 1'b0;
        else refclk_locked = 1'b0;
        ticks(2);
        compared++; if (state !== S_TRAIN) begin mismatched++; $display("FAIL drop_sync_delay: got %0d want %0d", state, S_TRAIN); end
        tick();
        retry_exp = 0;
        compared++; if (state !== S_WAIT || oc0a_perstn !== 1'b0 || rp_rstn !== 1'b0) begin mismatched++; $display("FAIL drop_wait: got state=%0d perstn=%b rp=%b want 1 0 0", state, oc0a_perstn, rp_rstn); end
        compared++; if (retry_cnt !== 4'd0 || down_cnt !== 8'(down_exp)) begin mismatched++; $display("FAIL drop_counts: got retry=%0d down=%0d want 0 %0d", retry_cnt, down_cnt, down_exp); end
        host_perstn   = 1'b1;
        refclk_locked = 1'b1;
        wait_state(S_HOLD, 10, n);
        compared++; if (n !== 3) begin mismatched++; $display("FAIL drop_recover: got %0d want 3", n); end
    endtask

    task automatic test_rstn_mid_hold();
        int n;
        ticks($urandom_range(T_PERST - 3, 1));
        #2;
        rstn = 1'b0;
        #1;
        down_exp = 0;
        compared++; if (state !== S_RESET || oc0a_perstn !== 1'b0 || rp_rstn !== 1'b0) begin mismatched++; $display("FAIL async_rst_state: got state=%0d perstn=%b rp=%b want 0 0 0", state, oc0a_perstn, rp_rstn); end
        compared++; if (down_cnt !== 8'd0 || retry_cnt !== 4'd0 || link_ready !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL async_rst_status: got down=%0d retry=%0d ready=%b fail=%b want 0 0 0 0", down_cnt, retry_cnt, link_ready, fail); end
        ticks(2);
        rstn = 1'b1;
        wait_state(S_HOLD, 10, n);
        compared++; if (n !== 3) begin mismatched++; $display("FAIL rst_restart: got %0d want 3", n); end
        link_up = 1'b1;
        wait_state(S_UP, 60, n);
        compared++; if (n !== T_PERST + 1 || down_cnt !== 8'(down_exp)) begin mismatched++; $display("FAIL rst_relink: got n=%0d down=%0d want %0d %0d", n, down_cnt, T_PERST + 1, down_exp); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_link_loss();
        test_retry_fail();
        test_simultaneous();
        test_host_perst();
        test_rstn_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
